// File: rtl/gru_pkg.sv
// gru_pkg: shared constants, saturation helpers and FSM states for the GRU update sequencer
package gru_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_FRAC_BITS = 4;
   function automatic int one_of(int fb);
      return 1 << fb;
   endfunction
   function automatic int sat_max(int dw);
      return (1 << (dw - 1)) - 1;
   endfunction
   function automatic int sat_min(int dw);
      return -(1 << (dw - 1));
   endfunction
   localparam int ONE = one_of(DEF_FRAC_BITS);
   localparam int SAT_MAX = sat_max(DEF_DATA_WIDTH);
   localparam int SAT_MIN = sat_min(DEF_DATA_WIDTH);
   typedef enum logic [2:0] {IDLE, READ, MUL1, MUL2, WRITE, FIN} state_t;
endpackage

// File: rtl/gru_update_sequencer_if.sv
// gru_update_sequencer_if: host handshake plus gate/candidate read port and hidden-state write port
interface gru_update_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  start, busy, done;
   logic                  rd_en, wr_en;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic [DATA_WIDTH-1:0] z_in, hprev_in, hcand_in, wr_data;
   modport master (
      input  start, z_in, hprev_in, hcand_in,
      output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
   modport slave (
      output start, z_in, hprev_in, hcand_in,
      input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/gru_one_minus.sv
// gru_one_minus: clamps the gate to ONE and returns both the clamped gate and ONE minus it
module gru_one_minus
   import gru_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS = 4
) (
   input  logic [DATA_WIDTH-1:0] z,
   output logic [DATA_WIDTH-1:0] zc,
   output logic [DATA_WIDTH-1:0] omz
);
   localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(one_of(FRAC_BITS));
   always_comb begin
      zc = (z > ONE_W) ? ONE_W : z;
      omz = ONE_W - zc;
   end
endmodule

// File: rtl/gru_update_sequencer.sv
// gru_update_sequencer: h_new = (1-z)*h_prev + z*h_cand per element, one shared multiplier, 4 cycles/element
module gru_update_sequencer
   import gru_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS = 4,
   parameter int N_ELEM = 16,
   parameter int ADDR_WIDTH = 4
) (
   input logic clk,
   input logic rst_n,
   gru_update_sequencer_if.master bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_ELEM - 1);
   localparam int SMAX = sat_max(DATA_WIDTH);
   localparam int SMIN = sat_min(DATA_WIDTH);
   state_t state, nxt;
   logic [ADDR_WIDTH-1:0] idx;
   logic [DATA_WIDTH-1:0] zr, hcr, zc, omz, wdata, sat;
   logic signed [DATA_WIDTH:0] op_a;
   logic signed [DATA_WIDTH-1:0] op_b;
   logic signed [2*DATA_WIDTH:0] prod, prod_a;
   logic signed [2*DATA_WIDTH+1:0] sum, res;
   gru_one_minus #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_om (
      .z  (state == MUL1 ? bus.z_in : zr),
      .zc (zc),
      .omz(omz)
   );
   // MUL1 forms (1-z)*h_prev from live inputs; MUL2 reuses the multiplier for z*h_cand
   always_comb begin
      op_a = (state == MUL1) ? $signed({1'b0, omz}) : $signed({1'b0, zc});
      op_b = (state == MUL1) ? $signed(bus.hprev_in) : $signed(hcr);
      prod = op_a * op_b;
      sum = prod_a + prod;
      res = sum >>> FRAC_BITS;
      sat = (res > SMAX) ? DATA_WIDTH'(SMAX) : (res < SMIN) ? DATA_WIDTH'(SMIN) : res[DATA_WIDTH-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         zr <= '0;
         hcr <= '0;
         prod_a <= '0;
         wdata <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && bus.start) idx <= '0;
         if (state == WRITE && idx != LAST) idx <= idx + 1'b1;
         if (state == MUL1) begin
            zr <= zc;
            hcr <= bus.hcand_in;
            prod_a <= prod;
         end
         if (state == MUL2) wdata <= sat;
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.start ? READ : IDLE;
         READ:    nxt = MUL1;
         MUL1:    nxt = MUL2;
         MUL2:    nxt = WRITE;
         WRITE:   nxt = (idx == LAST) ? FIN : READ;
         default: nxt = IDLE;
      endcase
      bus.busy = (state != IDLE) && (state != FIN);
      bus.done = (state == FIN);
      bus.rd_en = (state == READ);
      bus.wr_en = (state == WRITE);
      bus.rd_addr = idx;
      bus.wr_addr = idx;
      bus.wr_data = wdata;
   end
endmodule

// File: tb/tb_gru_update_sequencer.sv
// tb_gru_update_sequencer: vector-table full run, ignored re-start, hold, and mid-run async reset
module tb_gru_update_sequencer;
   typedef struct packed {
      logic [7:0] z, hp, hc, exp;
   } vec_t;
   vec_t tbl[16];
   logic clk = 0;
   logic rst_n = 0;
   int checks = 0;
   int errors = 0;
   int nwr;
   gru_update_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus();
   gru_update_sequencer #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_ELEM(16), .ADDR_WIDTH(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (bus.rd_en) begin
         bus.z_in <= tbl[bus.rd_addr].z;
         bus.hprev_in <= tbl[bus.rd_addr].hp;
         bus.hcand_in <= tbl[bus.rd_addr].hc;
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   initial begin
      tbl[0]  = '{8'h08, 8'h20, 8'h40, 8'h30};
      tbl[1]  = '{8'h04, 8'hF0, 8'h10, 8'hF8};
      tbl[2]  = '{8'h1F, 8'h55, 8'h30, 8'h30};
      tbl[3]  = '{8'h00, 8'h80, 8'h12, 8'h80};
      tbl[4]  = '{8'h01, 8'h00, 8'hFF, 8'hFF};
      tbl[5]  = '{8'h10, 8'h12, 8'h7F, 8'h7F};
      tbl[6]  = '{8'h00, 8'h7F, 8'h00, 8'h7F};
      tbl[7]  = '{8'h08, 8'h80, 8'h7F, 8'hFF};
      tbl[8]  = '{8'h0C, 8'h10, 8'h20, 8'h1C};
      tbl[9]  = '{8'h02, 8'hE0, 8'hE0, 8'hE0};
      tbl[10] = '{8'h03, 8'h01, 8'h00, 8'h00};
      tbl[11] = '{8'h03, 8'hFF, 8'h00, 8'hFF};
      tbl[12] = '{8'hFF, 8'h00, 8'h80, 8'h80};
      tbl[13] = '{8'h11, 8'h40, 8'hC0, 8'hC0};
      tbl[14] = '{8'h0F, 8'h10, 8'h00, 8'h01};
      tbl[15] = '{8'h07, 8'h33, 8'h33, 8'h33};
      bus.start = 0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_wr_en", bus.wr_en, 0);
      chk("rst_wr_data", bus.wr_data, 0);
      chk("rst_rd_addr", bus.rd_addr, 0);
      rst_n = 1;
      @(negedge clk);
      bus.start = 1;
      @(posedge clk);
      #1 bus.start = 0;
      nwr = 0;
      for (int c = 1; c <= 72; c++) begin
         if (c == 10) bus.start = 1;
         if (c == 11) bus.start = 0;
         chk("busy", bus.busy, (c >= 1 && c <= 64) ? 1 : 0);
         chk("done", bus.done, (c == 65) ? 1 : 0);
         chk("overlap", bus.rd_en & bus.wr_en, 0);
         chk("rd_en", bus.rd_en, (c <= 64 && c % 4 == 1) ? 1 : 0);
         chk("wr_en", bus.wr_en, (c <= 64 && c % 4 == 0) ? 1 : 0);
         if (bus.rd_en) chk("rd_addr", bus.rd_addr, (c - 1) / 4);
         if (bus.wr_en && nwr < 16) begin
            chk("wr_addr", bus.wr_addr, nwr);
            chk("wr_data", bus.wr_data, tbl[nwr].exp);
            nwr++;
         end
         if (c == 68) chk("wr_data_hold", bus.wr_data, tbl[15].exp);
         @(posedge clk);
         #1;
      end
      chk("wr_count", nwr, 16);
      @(negedge clk);
      bus.start = 1;
      @(posedge clk);
      #1 bus.start = 0;
      nwr = 0;
      for (int c = 1; c <= 40 && nwr < 3; c++) begin
         if (bus.wr_en) nwr++;
         if (nwr < 3) begin
            @(posedge clk);
            #1;
         end
      end
      chk("third_write_seen", nwr, 3);
      #2 rst_n = 0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_rd_en", bus.rd_en, 0);
      chk("arst_wr_en", bus.wr_en, 0);
      chk("arst_rd_addr", bus.rd_addr, 0);
      chk("arst_wr_addr", bus.wr_addr, 0);
      chk("arst_wr_data", bus.wr_data, 0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("rst_hold_wr_en", bus.wr_en, 0);
         chk("rst_hold_done", bus.done, 0);
      end
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_idle", bus.busy | bus.wr_en | bus.done, 0);
      end
      bus.start = 1;
      @(posedge clk);
      #1 bus.start = 0;
      for (int c = 1; c <= 5; c++) begin
         chk("rerun_wr_en", bus.wr_en, (c == 4) ? 1 : 0);
         if (bus.wr_en) begin
            chk("rerun_wr_addr", bus.wr_addr, 0);
            chk("rerun_wr_data", bus.wr_data, tbl[0].exp);
         end
         @(posedge clk);
         #1;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/gru_update_sequencer.md
Name: gru_update_sequencer

Overview:
- Sequences the GRU hidden-state update h_new[i] = (1 - z[i])*h_prev[i] + z[i]*h_cand[i] over a vector of N_ELEM elements.
- Uses one shared one-minus unit and one shared multiplier, time-multiplexed across both products.
- Sits between the gate/candidate buffers (read port) and the hidden-state buffer (write port).
- Host uses a start/busy/done handshake.

Parameters:
- DATA_WIDTH, 8, element width, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 4, fractional bits; ONE = 1 << FRAC_BITS (0x10 at defaults).
- N_ELEM, 16, vector length per run.
- ADDR_WIDTH, 4, buffer address width; must satisfy 2^ADDR_WIDTH >= N_ELEM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run.
- rd_en  out  1  read strobe to z/h_prev/h_cand buffers.
- rd_addr  out  ADDR_WIDTH  element index being read.
- z_in  in  DATA_WIDTH  unsigned gate value; valid the cycle after rd_en.
- hprev_in  in  DATA_WIDTH  signed previous hidden value; same timing as z_in.
- hcand_in  in  DATA_WIDTH  signed candidate value; same timing as z_in.
- wr_en  out  1  write strobe to hidden-state buffer.
- wr_addr  out  ADDR_WIDTH  write index.
- wr_data  out  DATA_WIDTH  signed h_new.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; busy, done, rd_en and wr_en = 0; rd_addr, wr_addr and wr_data = 0; index and internal registers = 0.
- FSM states: IDLE, READ, MUL1, MUL2, WRITE, FIN.
- IDLE: when start=1, clear idx and go to READ. busy rises on that next cycle.
- READ:
  - rd_en=1, rd_addr=idx.
  - Go to MUL1.
- MUL1:
  - Register z_in, hprev_in and hcand_in.
  - Clamp z: if z_in > ONE, use ONE.
  - omz = ONE - zc, computed by the sub-module.
  - Product A = omz * hprev, signed, 2*DATA_WIDTH+1 bits.
  - Go to MUL2.
- MUL2:
  - Product B = zc * hcand, with the multiplier muxed to its second operand pair.
  - Go to WRITE.
- WRITE:
  - sum = A + B, 2*DATA_WIDTH+2 bits.
  - res = sum arithmetically shifted right by FRAC_BITS (truncation toward -inf).
  - Saturate res to the signed DATA_WIDTH range. This is defensive only: the clamped convex combination is always in range.
  - wr_en=1, wr_addr=idx, wr_data=res.
  - If idx == N_ELEM-1, go to FIN. Otherwise idx++ and go to READ.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- Timing:
  - Each element takes 4 cycles.
  - First rd_en is asserted 1 cycle after start is sampled.
  - done arrives 4*N_ELEM+1 cycles after start is sampled.
- Strobes: rd_en and wr_en are single-cycle pulses; they are never asserted together.
- wr_data holds its last value when wr_en=0.
- start while busy (any non-IDLE state) is ignored; no queuing.
- start held high across FIN: a new run begins on the first IDLE cycle.
- Reset mid-run: immediate return to IDLE, no further writes, no done pulse. Partially written buffer contents are the owner's concern.
- idx never wraps past N_ELEM-1; rd_addr and wr_addr stay below N_ELEM.

Decomposition:
- Shared package gru_pkg:
  - ONE constant (derived from FRAC_BITS).
  - State enum.
  - Saturation limits SAT_MAX and SAT_MIN.
- One sub-module gru_one_minus:
  - Combinational ONE - z with clamp of z to ONE.
  - DATA_WIDTH and FRAC_BITS parameterized.
  - Instantiated once.
- Multiplier and accumulate logic stay inline.

Test Plan:
- Basic combine: z=0x08, hprev=0x20, hcand=0x40 at idx 0 -> wr_data=0x30 (3.0), wr_addr=0.
- Signed mix: z=0x04, hprev=0xF0, hcand=0x10 -> wr_data=0xF8 (-0.5).
- Clamp: z=0x1F, hprev=0x55, hcand=0x30 -> wr_data=0x30 (treated as z=ONE); z=0x00, hprev=0x80 -> 0x80.
- Truncation: z=0x01, hprev=0x00, hcand=0xFF -> wr_data=0xFF (-1 >>> 4).
- Full run, N_ELEM=16: start pulse -> exactly 16 wr_en pulses at addrs 0..15, each 4 cycles apart; done at cycle 65 after start; busy high cycles 1..64; start re-pulsed at cycle 10 has no effect.
- Reset mid-run: assert rst_n=0 after the 3rd write -> all outputs 0 asynchronously, no done pulse. After release, a new start runs from addr 0.
